// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: valid/ready request and result bundle for bin_to_bcd_seq
interface bin_to_bcd_seq_if #(parameter int WIDTH = 16, parameter int DIGITS = 5);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      bin_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  neg;
  modport master (output in_valid, bin_in, out_ready, input in_ready, out_valid, bcd_out, neg);
  modport slave  (input in_valid, bin_in, out_ready, output in_ready, out_valid, bcd_out, neg);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary to BCD converter, one bit per clock.
// Define BIN_TO_BCD_SIGNED_EN to treat bin_in as two's complement and report the sign on neg.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input logic               clk,
  input logic               rst_n,
  bin_to_bcd_seq_if.slave   bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t              state, state_nx;
  logic [4*DIGITS-1:0] acc, adj, acc_nx, bcd_r;
  logic [WIDTH-1:0]    opnd, mag;
  logic [CW-1:0]       cnt;
  logic                accept, last;
  assign accept = state == IDLE && bus.in_valid;
  assign last   = state == SHIFT && cnt == CW'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = bus.in_valid ? SHIFT : IDLE;
      SHIFT:   state_nx = cnt == CW'(1) ? DONE : SHIFT;
      DONE:    state_nx = bus.out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready  = state == IDLE;
    bus.out_valid = state == DONE;
  end
  always_comb begin
    adj = acc;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
  end
  assign acc_nx = {adj[4*DIGITS-2:0], opnd[WIDTH-1]};
  // Working accumulator stays internal; bcd_r only updates on the final shift.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc   <= '0;
      opnd  <= '0;
      cnt   <= '0;
      bcd_r <= '0;
    end else if (accept) begin
      acc  <= '0;
      opnd <= mag;
      cnt  <= CW'(WIDTH);
    end else if (state == SHIFT) begin
      acc  <= acc_nx;
      opnd <= opnd << 1;
      cnt  <= cnt - CW'(1);
      if (last) bcd_r <= acc_nx;
    end
  assign bus.bcd_out = bcd_r;
`ifdef BIN_TO_BCD_SIGNED_EN
  logic neg_p, neg_r;
  assign mag = bus.bin_in[WIDTH-1] ? WIDTH'(0) - bus.bin_in : bus.bin_in;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      neg_p <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) neg_p <= bus.bin_in[WIDTH-1];
    else if (last) neg_r <= neg_p;
  assign bus.neg = neg_r;
`else
  assign mag     = bus.bin_in;
  assign bus.neg = 1'b0;
`endif
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench for bin_to_bcd_seq (either build of BIN_TO_BCD_SIGNED_EN).
module tb_bin_to_bcd_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0;
  int bad = 0;
  logic [20:0] q[$];
  bin_to_bcd_seq_if #(.WIDTH(16), .DIGITS(5)) bus ();
  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [20:0] model(input logic [15:0] v);
    logic [15:0] m;
    logic n;
    int u;
    logic [19:0] r;
`ifdef BIN_TO_BCD_SIGNED_EN
    n = v[15];
    m = n ? 16'(0 - int'(v)) : v;
`else
    n = 1'b0;
    m = v;
`endif
    u = int'(m);
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(u % 10);
      u = u / 10;
    end
    return {n, r};
  endfunction
  always @(negedge clk)
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) check("extra_result", 32'(q.size()), 32'd1);
      else begin
        logic [20:0] e;
        logic ok;
        e = q.pop_front();
        ok = 1'b1;
        for (int k = 0; k < 5; k++) if (bus.bcd_out[4*k +: 4] > 4'd9) ok = 1'b0;
        check("bcd", 32'(bus.bcd_out), 32'(e[19:0]));
        check("neg", 32'(bus.neg), 32'(e[20]));
        check("nibble_range", 32'(ok), 32'd1);
      end
    end
  task automatic send(input logic [15:0] v);
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("ready_timeout", 32'(n), 32'd0);
    bus.bin_in = v;
    bus.in_valid = 1'b1;
    q.push_back(model(v));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.bin_in = 16'($urandom);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("idle_timeout", 32'(n), 32'd0);
  endtask
  initial begin
    int n, last_acc, idx;
    logic seen;
    logic [15:0] vals[3];
    bus.in_valid = 1'b0;
    bus.bin_in = '0;
    bus.out_ready = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_bcd", 32'(bus.bcd_out), 32'd0);
    check("rst_neg", 32'(bus.neg), 32'd0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;
    // zero input: latency counted from the accepting edge
    send(16'd0);
    n = 1;
    while (!bus.out_valid && n < 100) begin
      check("busy_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    check("latency", 32'(n), 32'd17);
    check("done_in_ready", 32'(bus.in_ready), 32'd0);
    wait_idle();
    send(16'd65535); wait_idle();
    send(16'd12345); wait_idle();
    send(16'h8000);  wait_idle();
    send(16'hFFE7);  wait_idle();
    send(16'd25);    wait_idle();
    for (int i = 0; i < 5; i++) begin
      send(16'($urandom));
      wait_idle();
    end
    // result held while the consumer stalls
    bus.out_ready = 1'b0;
    send(16'd987);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_bcd", 32'(bus.bcd_out), 32'h00987);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("hold_release_idle", 32'(bus.in_ready), 32'd1);
    // back-to-back with in_valid held high and garbage on bin_in while busy
    vals = '{16'd100, 16'd200, 16'd300};
    idx = 0;
    last_acc = 0;
    n = 0;
    bus.in_valid = 1'b1;
    while (idx < 3 && n < 200) begin
      bus.bin_in = bus.in_ready ? vals[idx] : 16'($urandom);
      seen = bus.in_ready;
      if (seen) q.push_back(model(vals[idx]));
      @(posedge clk); #1;
      n++;
      if (seen) begin
        if (idx > 0) check("b2b_gap", 32'(n - last_acc), 32'd18);
        last_acc = n;
        idx++;
      end
    end
    check("b2b_count", 32'(idx), 32'd3);
    bus.in_valid = 1'b0;
    wait_idle();
    // reset during SHIFT aborts the conversion
    send(16'd4321);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    void'(q.pop_back());
    #1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("abort_no_result", 32'(seen), 32'd0);
    send(16'd42);
    wait_idle();
    @(posedge clk); #1;
    check("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
